// File: rtl/seq_detect_param_if.sv
// Serial pattern-detector bus: stream/control inputs from the master, match results back from the slave.
interface seq_detect_param_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               en_i;
    logic               in_i;
    logic               pat_wr_i;
    logic [PAT_LEN-1:0] pat_data_i;
    logic               cnt_clr_i;
    logic               out_o;
    logic               out_q_o;
    logic [CNT_W-1:0]   match_cnt_o;

    modport master (
        output en_i, in_i, pat_wr_i, pat_data_i, cnt_clr_i,
        input  out_o, out_q_o, match_cnt_o
    );

    modport slave (
        input  en_i, in_i, pat_wr_i, pat_data_i, cnt_clr_i,
        output out_o, out_q_o, match_cnt_o
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector with a reloadable pattern, optional overlap,
// a clock enable, a registered match strobe and a saturating match counter.
module seq_detect_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input logic               clk,
    input logic               rst,
    seq_detect_param_if.slave bus
);
    localparam int                FILL_W   = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q;
    logic [PAT_LEN-1:0] window;
    logic               match;

    // The window is the stored history plus the bit arriving this cycle.
    assign window = {hist_q, bus.in_i};
    assign match  = bus.en_i & ~bus.pat_wr_i & (fill_q == FILL_MAX) & (window == pat_q);

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        if (bus.pat_wr_i) begin
            pat_d  = bus.pat_data_i;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en_i) begin
            hist_d = window[PAT_LEN-2:0];
            if (match && !OVERLAP) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
        // A coincident clear drops the match rather than counting it.
        if (bus.cnt_clr_i) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_q   <= PATTERN;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            match_q <= match;
        end
    end

    assign bus.out_o       = match;
    assign bus.out_q_o     = match_q;
    assign bus.match_cnt_o = cnt_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Drives three detector variants (overlapping, non-overlapping, 2-bit counter) with one
// shared stream and compares each against a bit-stream reference model.
module tb_seq_detect_param;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       din;
    logic       patWr;
    logic [3:0] patData;
    logic       cntClr;

    int testsRun    = 0;
    int testsFailed = 0;

    seq_detect_param_if #(.PAT_LEN(4), .CNT_W(8)) ifc0 ();
    seq_detect_param_if #(.PAT_LEN(4), .CNT_W(8)) ifc1 ();
    seq_detect_param_if #(.PAT_LEN(4), .CNT_W(2)) ifc2 ();

    assign ifc0.en_i = en;      assign ifc1.en_i = en;      assign ifc2.en_i = en;
    assign ifc0.in_i = din;     assign ifc1.in_i = din;     assign ifc2.in_i = din;
    assign ifc0.pat_wr_i = patWr;   assign ifc1.pat_wr_i = patWr;   assign ifc2.pat_wr_i = patWr;
    assign ifc0.pat_data_i = patData; assign ifc1.pat_data_i = patData; assign ifc2.pat_data_i = patData;
    assign ifc0.cnt_clr_i = cntClr; assign ifc1.cnt_clr_i = cntClr; assign ifc2.cnt_clr_i = cntClr;

    seq_detect_param u0 (.clk(clk), .rst(rst), .bus(ifc0.slave));
    seq_detect_param #(.OVERLAP(1'b0)) u1 (.clk(clk), .rst(rst), .bus(ifc1.slave));
    seq_detect_param #(.CNT_W(2)) u2 (.clk(clk), .rst(rst), .bus(ifc2.slave));

    always #5 clk = ~clk;

    // Reference model: count of usable bits received since the last restart plus the raw bit history.
    logic [31:0] mHist  [3];
    int          mValid [3];
    logic [3:0]  mPat   [3];
    int          mOutQ  [3];
    int          mCnt   [3];
    int          mMax   [3] = '{255, 255, 3};
    int          mOver  [3] = '{1, 0, 1};

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int expMatch(input int k);
        logic [31:0] last4;
        last4 = ((mHist[k] << 1) | {31'd0, din}) & 32'hF;
        return (en && !patWr && (mValid[k] >= 3) && (last4 == {28'd0, mPat[k]})) ? 1 : 0;
    endfunction

    function automatic int obsOut(input int k);
        case (k)
            0: return int'(ifc0.out_o);
            1: return int'(ifc1.out_o);
            default: return int'(ifc2.out_o);
        endcase
    endfunction

    function automatic int obsOutQ(input int k);
        case (k)
            0: return int'(ifc0.out_q_o);
            1: return int'(ifc1.out_q_o);
            default: return int'(ifc2.out_q_o);
        endcase
    endfunction

    function automatic int obsCnt(input int k);
        case (k)
            0: return int'(ifc0.match_cnt_o);
            1: return int'(ifc1.match_cnt_o);
            default: return int'(ifc2.match_cnt_o);
        endcase
    endfunction

    // One clock cycle: drive at the falling edge, check out before the rising edge,
    // then update the model and check registered outputs just after it.
    task automatic applyStimulus(input logic r, input logic e, input logic d,
                                 input logic pw, input logic [3:0] pd, input logic clr);
        int em [3];
        rst = r; en = e; din = d; patWr = pw; patData = pd; cntClr = clr;
        #1;
        for (int k = 0; k < 3; k++) begin
            em[k] = expMatch(k);
            checkOutput($sformatf("out%0d", k), obsOut(k), em[k]);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (!r) begin
                mPat[k] = 4'b1001; mHist[k] = 0; mValid[k] = 0; mOutQ[k] = 0; mCnt[k] = 0;
            end else begin
                mOutQ[k] = em[k];
                if (clr) mCnt[k] = 0;
                else if (em[k] == 1 && mCnt[k] < mMax[k]) mCnt[k]++;
                if (pw) begin
                    mPat[k] = pd; mHist[k] = 0; mValid[k] = 0;
                end else if (e) begin
                    mHist[k] = (mHist[k] << 1) | {31'd0, d};
                    if (em[k] == 1 && mOver[k] == 0) mValid[k] = 0;
                    else mValid[k]++;
                end
            end
            checkOutput($sformatf("out_q%0d", k), obsOutQ(k), mOutQ[k]);
            checkOutput($sformatf("cnt%0d", k), obsCnt(k), mCnt[k]);
        end
        @(negedge clk);
    endtask

    task automatic feedBits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) applyStimulus(1'b1, 1'b1, bits[i], 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        int c0, c1;
        rst = 1'b0; en = 1'b0; din = 1'b0; patWr = 1'b0; patData = 4'd0; cntClr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mHist[k] = 0; mValid[k] = 0; mPat[k] = 4'b1001; mOutQ[k] = 0; mCnt[k] = 0;
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

        // Overlapping vs non-overlapping on 1,0,0,1,0,0,1 then 1,0,0,1.
        feedBits(32'b1001001, 7);
        checkOutput("t1_cnt_overlap", obsCnt(0), 2);
        checkOutput("t1_cnt_nonoverlap", obsCnt(1), 1);
        feedBits(32'b1001, 4);
        checkOutput("t2_cnt_nonoverlap", obsCnt(1), 2);

        // Two more matches: the 2-bit counter sticks at 3, then a clear beats a match.
        feedBits(32'b001001, 6);
        checkOutput("t5_cnt_wide", obsCnt(0), 5);
        checkOutput("t5_cnt_sat", obsCnt(2), 3);
        feedBits(32'b00, 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        checkOutput("t5_clr_wide", obsCnt(0), 0);
        checkOutput("t5_clr_sat", obsCnt(2), 0);

        // Reset mid-pattern discards history.
        feedBits(32'b100, 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        feedBits(32'b1, 1);
        checkOutput("t6_no_match", obsCnt(0), 0);
        feedBits(32'b001, 3);
        checkOutput("t6_match0", obsCnt(0), 1);
        checkOutput("t6_match1", obsCnt(1), 1);

        // Enable gaps with random data in the disabled cycles.
        c0 = obsCnt(0); c1 = obsCnt(1);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] pat;
            pat = 4'b1001;
            applyStimulus(1'b1, 1'b1, pat[i], 1'b0, 4'd0, 1'b0);
            for (int g = 0; g < 3; g++)
                applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'd0, 1'b0);
        end
        checkOutput("t3_gap_overlap", obsCnt(0) - c0, 1);
        checkOutput("t3_gap_nonoverlap", obsCnt(1) - c1, 1);

        // Runtime reload to 1101 after a partial 1,0,0.
        feedBits(32'b100, 3);
        c0 = obsCnt(0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b1101, 1'b0);
        feedBits(32'b1101, 4);
        checkOutput("t4_reload_match", obsCnt(0) - c0, 1);
        feedBits(32'b1001, 4);
        checkOutput("t4_old_pattern", obsCnt(0) - c0, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic r, e, d, pw, clr;
            logic [3:0] pd;
            r   = ($urandom_range(0, 99) != 0);
            e   = ($urandom_range(0, 3) != 0);
            d   = 1'($urandom_range(0, 1));
            pw  = ($urandom_range(0, 49) == 0);
            pd  = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 59) == 0);
            applyStimulus(r, e, d, pw, pd, clr);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
